// File: rtl/uart_boot_loader_if.sv
// Purpose : bundles the UART byte input and instruction-memory/core-control outputs of the boot loader.
// Latency : n/a (wires only).
// Backpress: none; rx_valid is a one-cycle pulse and the loader always accepts it.
// Ports   : rx_valid/rx_byte (UART side), imem_we/be/addr/wdata (memory side),
//           cpu_rst_n/load_done/byte_count/overflow (core control and status).
interface uart_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                    rx_valid;
    logic [7:0]              rx_byte;
    logic                    imem_we;
    logic [3:0]              imem_be;
    logic [ADDR_WIDTH-3:0]   imem_addr;
    logic [31:0]             imem_wdata;
    logic                    cpu_rst_n;
    logic                    load_done;
    logic [ADDR_WIDTH:0]     byte_count;
    logic                    overflow;

    // Environment side: produces UART bytes, consumes memory writes and status.
    modport master (
        output rx_valid, rx_byte,
        input  imem_we, imem_be, imem_addr, imem_wdata,
        input  cpu_rst_n, load_done, byte_count, overflow
    );

    // Loader side.
    modport slave (
        input  rx_valid, rx_byte,
        output imem_we, imem_be, imem_addr, imem_wdata,
        output cpu_rst_n, load_done, byte_count, overflow
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Purpose : packs UART bytes into little-endian 32-bit instruction-memory writes, holds the core in reset until
//           the program ends (four consecutive 0xFF bytes or an idle timeout), then releases it.
// Latency : write 1 cycle after the byte completing a word or ending the load; load_done 2 cycles after the end.
// Backpress: none; bytes may arrive every cycle, bytes past memory capacity are dropped and flagged in overflow.
// Ports   : sys_clk, rst (async active-low), bus (uart_boot_loader_if.slave).
module uart_boot_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic               sys_clk,
    input  logic               rst,
    uart_boot_loader_if.slave  bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [31:0]           r_hold;
    logic [1:0]            r_run;
    logic [TW-1:0]         r_idle;
    logic                  r_ovf;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [ADDR_WIDTH-3:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_cpu_rst_n;
    logic                  r_load_done;

    // Outside LOAD a byte starts a fresh load, so the per-load state is seen as zero.
    logic                  w_in_load;
    logic [CW-1:0]         w_cnt;
    logic [31:0]           w_hold;
    logic [1:0]            w_run;
    logic                  w_byte;
    logic                  w_store;
    logic [1:0]            w_lane;
    logic [31:0]           w_hold_nxt;
    logic                  w_halt;
    logic                  w_tmo;
    logic                  w_term;
    logic                  w_word_full;
    logic [2:0]            w_nfill;
    logic                  w_wr;
    logic [3:0]            w_be;

    assign w_in_load   = (r_state == S_LOAD);
    assign w_cnt       = w_in_load ? r_count : '0;
    assign w_hold      = w_in_load ? r_hold  : '0;
    assign w_run       = w_in_load ? r_run   : '0;
    // Bytes arriving during the single RELEASE cycle are discarded.
    assign w_byte      = bus.rx_valid && (r_state != S_RELEASE);
    // Top count bit set means memory is full.
    assign w_store     = w_byte && !w_cnt[ADDR_WIDTH];
    assign w_lane      = w_cnt[1:0];
    assign w_hold_nxt  = w_store ? (w_hold | ({24'b0, bus.rx_byte} << {w_lane, 3'b000})) : w_hold;
    // Fourth consecutive 0xFF, regardless of word alignment or whether it was stored.
    assign w_halt      = w_byte && (bus.rx_byte == 8'hFF) && (w_run == 2'd3);
    // A byte on the timeout cycle wins over the timeout.
    assign w_tmo       = w_in_load && !bus.rx_valid && (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign w_term      = w_in_load && (w_halt || w_tmo);
    assign w_word_full = w_store && (w_lane == 2'd3);
    assign w_nfill     = w_store ? ({1'b0, w_lane} + 3'd1) : {1'b0, w_lane};
    // A full word and a termination on the same byte give one write with all lanes.
    assign w_wr        = w_word_full || (w_term && (w_nfill != 3'd0));
    assign w_be        = ~(4'b1111 << w_nfill);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_hold      <= '0;
            r_run       <= '0;
            r_idle      <= '0;
            r_ovf       <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_load_done <= 1'b0;

            if (w_wr) begin
                r_we    <= 1'b1;
                r_be    <= w_be;
                r_addr  <= w_cnt[ADDR_WIDTH-1:2];
                r_wdata <= w_hold_nxt;
            end

            if (w_byte) begin
                r_count <= w_store ? (w_cnt + CW'(1)) : w_cnt;
                r_ovf   <= (w_in_load && r_ovf) || !w_store;
                r_hold  <= (w_word_full || w_term) ? '0 : w_hold_nxt;
                r_run   <= (bus.rx_byte == 8'hFF) ? (w_run + 2'd1) : 2'd0;
                r_idle  <= '0;
            end else if (w_in_load) begin
                r_idle  <= r_idle + TW'(1);
                if (w_tmo) begin
                    r_hold <= '0;
                end
            end

            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_byte) begin
                        r_state     <= S_LOAD;
                        r_cpu_rst_n <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_term) begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_state     <= S_RUN;
                    r_cpu_rst_n <= 1'b1;
                    r_load_done <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_be    = r_be;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_rst_n  = r_cpu_rst_n;
    assign bus.load_done  = r_load_done;
    assign bus.byte_count = r_count;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Purpose : self-checking bench for uart_boot_loader with a byte-array reference model and directed literal cases.
// Latency : n/a.
// Backpress: n/a.
module tb_uart_boot_loader;
    localparam int AW        = 4;
    localparam int TMO       = 50;
    localparam int MEM_BYTES = 1 << AW;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [AW-3:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
    } wr_t;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    uart_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: bytes kept in an array, timeout by cycle distance ----------------
    typedef enum {M_IDLE, M_LOAD, M_RELEASE, M_RUN} mmode_t;
    mmode_t       m_mode = M_IDLE;
    logic [7:0]   mem [MEM_BYTES];
    int           m_nb = 0;
    bit           m_ovf = 0;
    int           m_ff = 0;
    int           m_cyc = 0;
    int           m_last = 0;
    bit           m_term, m_wrote;
    logic         e_we = 0, e_cpu = 0, e_done = 0;
    logic [3:0]   e_be = 0;
    logic [AW-3:0] e_addr = 0;
    logic [31:0]  e_wdata = 0;

    function automatic void expect_write(input int w, input int nl);
        logic [31:0] d;
        d = 32'h0;
        for (int l = 0; l < nl; l++) d = d | (32'(mem[4*w+l]) << (8*l));
        e_we    = 1'b1;
        e_be    = 4'((1 << nl) - 1);
        e_addr  = (AW-2)'(w);
        e_wdata = d;
    endfunction

    always @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE; m_nb = 0; m_ovf = 0; m_ff = 0; m_cyc = 0; m_last = 0;
            e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_cpu = 0; e_done = 0;
        end else begin
            m_term = 0; m_wrote = 0; e_we = 0; e_done = 0;
            if (m_mode == M_RELEASE) begin
                m_mode = M_RUN; e_cpu = 1; e_done = 1;
            end else if (bus.rx_valid) begin
                if (m_mode != M_LOAD) begin
                    m_nb = 0; m_ovf = 0; m_ff = 0; m_mode = M_LOAD; e_cpu = 0;
                end
                m_last = m_cyc;
                if (m_nb < MEM_BYTES) begin
                    mem[m_nb] = bus.rx_byte;
                    m_nb++;
                    if (m_nb % 4 == 0) begin
                        expect_write((m_nb - 1) / 4, 4);
                        m_wrote = 1;
                    end
                end else begin
                    m_ovf = 1;
                end
                m_ff = (bus.rx_byte == 8'hFF) ? m_ff + 1 : 0;
                if (m_ff == 4) m_term = 1;
            end else if (m_mode == M_LOAD && (m_cyc - m_last) == TMO) begin
                m_term = 1;
            end
            if (m_term) begin
                if (!m_wrote && (m_nb % 4) != 0) expect_write(m_nb / 4, m_nb % 4);
                m_mode = M_RELEASE;
            end
            m_cyc++;
        end
    end

    // ---------------- compare process ----------------
    wr_t wlog[$];

    always @(negedge sys_clk) begin
        if (rst === 1'b1) begin
            check("imem_we", 32'(bus.imem_we), 32'(e_we));
            if (e_we) begin
                check("imem_be",    32'(bus.imem_be),   32'(e_be));
                check("imem_addr",  32'(bus.imem_addr), 32'(e_addr));
                check("imem_wdata", bus.imem_wdata,     e_wdata);
            end
            check("cpu_rst_n",  32'(bus.cpu_rst_n),  32'(e_cpu));
            check("load_done",  32'(bus.load_done),  32'(e_done));
            check("byte_count", 32'(bus.byte_count), 32'(m_nb));
            check("overflow",   32'(bus.overflow),   32'(m_ovf));
            if (bus.imem_we === 1'b1) wlog.push_back('{bus.imem_addr, bus.imem_be, bus.imem_wdata});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        bus.rx_valid = v;
        bus.rx_byte  = b;
    endtask

    task automatic send_seq(input byte_q_t q);
        foreach (q[i]) drive(1'b1, q[i]);
        drive(1'b0, 8'h00);
    endtask

    // Counts cycles from the one after the last byte until load_done (1 = that cycle).
    task automatic wait_done(output int k);
        k = 1;
        while (k < 200) begin
            @(negedge sys_clk);
            if (bus.load_done === 1'b1) break;
            k++;
        end
    endtask

    task automatic chk_log(input string nm, input int idx, input int addr, input logic [3:0] be, input logic [31:0] data);
        if (idx < wlog.size()) begin
            check({nm, "_addr"}, 32'(wlog[idx].addr), 32'(addr));
            check({nm, "_be"},   32'(wlog[idx].be),   32'(be));
            check({nm, "_data"}, wlog[idx].data,      data);
        end else begin
            check({nm, "_present"}, 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_we"},    32'(bus.imem_we),    32'h0);
        check({nm, "_be"},    32'(bus.imem_be),    32'h0);
        check({nm, "_addr"},  32'(bus.imem_addr),  32'h0);
        check({nm, "_wdata"}, bus.imem_wdata,      32'h0);
        check({nm, "_cpu"},   32'(bus.cpu_rst_n),  32'h0);
        check({nm, "_done"},  32'(bus.load_done),  32'h0);
        check({nm, "_cnt"},   32'(bus.byte_count), 32'h0);
        check({nm, "_ovf"},   32'(bus.overflow),   32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        byte_q_t q;
        logic [7:0] b;
        int g;

        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("reset");
        @(posedge sys_clk); #1; rst = 1'b1;

        // Full-word load ending in an aligned halt word.
        wlog.delete();
        q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_seq(q);
        wait_done(k);
        check("full_done_lat", 32'(k), 32'd2);
        check("full_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
        check("full_nwr", 32'(wlog.size()), 32'd3);
        chk_log("full_w0", 0, 0, 4'hF, 32'h0010_0093);
        chk_log("full_w1", 1, 1, 4'hF, 32'h0020_0113);
        chk_log("full_w2", 2, 2, 4'hF, 32'hFFFF_FFFF);
        check("full_cnt", 32'(bus.byte_count), 32'd12);

        // Compressed instruction misaligns the halt pattern.
        wlog.delete();
        q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'hF5, 8'h0E, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_seq(q);
        wait_done(k);
        check("cmp_done_lat", 32'(k), 32'd2);
        check("cmp_nwr", 32'(wlog.size()), 32'd3);
        chk_log("cmp_w0", 0, 0, 4'hF, 32'h0010_0093);
        chk_log("cmp_w1", 1, 1, 4'hF, 32'hFFFF_0EF5);
        chk_log("cmp_w2", 2, 2, 4'h3, 32'h0000_FFFF);
        check("cmp_cnt", 32'(bus.byte_count), 32'd10);

        // Idle timeout flushes a partial word.
        wlog.delete();
        q = '{8'h13, 8'h01, 8'h20};
        send_seq(q);
        k = 1;
        while (k < 200) begin
            @(negedge sys_clk);
            if (bus.imem_we === 1'b1) break;
            k++;
        end
        check("tmo_wr_lat", 32'(k), 32'd51);
        @(negedge sys_clk);
        check("tmo_done", 32'(bus.load_done), 32'd1);
        check("tmo_nwr", 32'(wlog.size()), 32'd1);
        chk_log("tmo_w0", 0, 0, 4'h7, 32'h0020_0113);

        // Overflow: 20 bytes into a 16-byte memory, then a dropped halt pattern.
        wlog.delete();
        q = {};
        for (int i = 1; i <= 20; i++) q.push_back(8'(i));
        for (int i = 0; i < 4; i++) q.push_back(8'hFF);
        send_seq(q);
        wait_done(k);
        check("ovf_done_lat", 32'(k), 32'd2);
        check("ovf_nwr", 32'(wlog.size()), 32'd4);
        chk_log("ovf_w0", 0, 0, 4'hF, 32'h0403_0201);
        chk_log("ovf_w1", 1, 1, 4'hF, 32'h0807_0605);
        chk_log("ovf_w2", 2, 2, 4'hF, 32'h0C0B_0A09);
        chk_log("ovf_w3", 3, 3, 4'hF, 32'h100F_0E0D);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_cnt", 32'(bus.byte_count), 32'd16);

        // Reload from RUN.
        wlog.delete();
        drive(1'b1, 8'hAA);
        drive(1'b0, 8'h00);
        @(negedge sys_clk);
        check("rld_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("rld_ovf", 32'(bus.overflow), 32'd0);
        check("rld_cnt", 32'(bus.byte_count), 32'd1);
        q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_seq(q);
        wait_done(k);
        check("rld_nwr", 32'(wlog.size()), 32'd2);
        chk_log("rld_w0", 0, 0, 4'hF, 32'hFFFF_FFAA);
        chk_log("rld_w1", 1, 1, 4'h1, 32'h0000_00FF);

        // Reset in the middle of a word.
        wlog.delete();
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b0, 8'h00);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge sys_clk); #1; rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("midrst_nwr", 32'(wlog.size()), 32'd0);

        // Randomized loads: halt-heavy bytes, bursts, gaps, timeouts and occasional resets.
        for (int l = 0; l < 40; l++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                drive(1'b1, b);
                g = $urandom_range(0, 39);
                if (g == 0)       g = TMO + 5;
                else if (g < 10)  g = $urandom_range(1, 3);
                else              g = 0;
                repeat (g) drive(1'b0, 8'h00);
                if ($urandom_range(0, 99) == 0) begin
                    @(posedge sys_clk); #1;
                    rst = 1'b0; bus.rx_valid = 1'b0;
                    @(posedge sys_clk); #1;
                    rst = 1'b1;
                end
            end
            repeat (TMO + 10) drive(1'b0, 8'h00);
        end

        repeat (2) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
